// File: rtl/mips_exec_ctrl_unit.sv
// +-------------------------------------------------------------------------+
// | mips_exec_ctrl_unit: main control, ALU control and ALU of a MIPS core   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module mips_exec_ctrl_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  instr,
   input  logic [N-1:0] rs_data,
   input  logic [N-1:0] rt_data,
   output logic         reg_dst,
   output logic         alu_src,
   output logic         mem_to_reg,
   output logic         reg_write,
   output logic         mem_read,
   output logic         mem_write,
   output logic         branch,
   output logic [1:0]   alu_op,
   output logic [3:0]   alu_ctl,
   output logic [N-1:0] imm_ext,
   output logic [N-1:0] alu_result,
   output logic         cout,
   output logic         slt,
   output logic         overflow,
   output logic         zero,
   output logic [N-1:0] result_q,
   output logic [3:0]   flags_q
);

   logic [5:0]   opcode;
   logic [3:0]   sel;
   logic [N-1:0] op_b;
   logic [N-1:0] b_eff;
   logic [N:0]   sum;
   logic         is_sub;
   logic         is_arith;
   logic [N-1:0] result_d;
   logic [3:0]   flags_d;
   logic         unused_bits;

   assign opcode      = instr[31:26];
   assign unused_bits = ^instr[25:16];
   assign imm_ext     = {{(N-16){instr[15]}}, instr[15:0]};

   always_comb begin
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      alu_op     = 2'b00;
      case (opcode)
         6'b000000: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            alu_op    = 2'b10;
         end
         6'b100011: begin
            alu_src    = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            mem_read   = 1'b1;
         end
         6'b101011: begin
            alu_src   = 1'b1;
            mem_write = 1'b1;
         end
         6'b000100: begin
            branch = 1'b1;
            alu_op = 2'b01;
         end
         6'b001000, 6'b001100, 6'b001101: begin
            alu_src   = 1'b1;
            reg_write = 1'b1;
            alu_op    = 2'b10;
         end
         default: ;
      endcase
   end

   // Immediate ops borrow the funct nibble of their R-type counterpart.
   always_comb begin
      case (opcode)
         6'b001000: sel = 4'b0000;
         6'b001100: sel = 4'b0100;
         6'b001101: sel = 4'b0101;
         default:   sel = instr[3:0];
      endcase
   end

   always_comb begin
      alu_ctl = 4'b0010;
      if (alu_op == 2'b01) begin
         alu_ctl = 4'b0110;
      end else if (alu_op[1]) begin
         case (sel)
            4'b0000: alu_ctl = 4'b0010;
            4'b0010: alu_ctl = 4'b0110;
            4'b0100: alu_ctl = 4'b0000;
            4'b0101: alu_ctl = 4'b0001;
            4'b1010: alu_ctl = 4'b0111;
            4'b0111: alu_ctl = 4'b1100;
            default: alu_ctl = 4'b0010;
         endcase
      end
   end

   // Shared adder: subtraction is A + ~B + 1 so carry and overflow share one path.
   always_comb begin
      op_b     = alu_src ? imm_ext : rt_data;
      is_sub   = (alu_ctl == 4'b0110);
      is_arith = is_sub || (alu_ctl == 4'b0010);
      b_eff    = is_sub ? ~op_b : op_b;
      sum      = {1'b0, rs_data} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
      slt      = ($signed(rs_data) < $signed(op_b));
      case (alu_ctl)
         4'b0000: alu_result = rs_data & op_b;
         4'b0001: alu_result = rs_data | op_b;
         4'b0010: alu_result = sum[N-1:0];
         4'b0110: alu_result = sum[N-1:0];
         4'b0111: alu_result = {{(N-1){1'b0}}, slt};
         4'b1100: alu_result = ~(rs_data | op_b);
         default: alu_result = '0;
      endcase
      cout     = is_arith & sum[N];
      overflow = is_arith & (rs_data[N-1] == b_eff[N-1]) & (sum[N-1] != rs_data[N-1]);
      zero     = (alu_result == '0);
   end

   always_comb begin
      result_d = alu_result;
      flags_d  = {cout, slt, overflow, zero};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mips_exec_ctrl_unit.sv
// +-------------------------------------------------------------------------+
// | tb_mips_exec_ctrl_unit: randomized scoreboard bench for the exec unit   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_mips_exec_ctrl_unit;

   localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_SLT = 4, OP_NOR = 5;

   typedef struct packed {
      logic [8:0]  ctrl;
      logic [3:0]  alu_ctl;
      logic [31:0] imm;
      logic [31:0] res;
      logic        cout;
      logic        slt;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
   logic [1:0]  alu_op;
   logic [3:0]  alu_ctl;
   logic [31:0] imm_ext;
   logic [31:0] alu_result;
   logic        cout, slt, overflow, zero;
   logic [31:0] result_q;
   logic [3:0]  flags_q;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic drv_valid = 1'b0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   mips_exec_ctrl_unit #(.N(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
      .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .alu_op(alu_op), .alu_ctl(alu_ctl), .imm_ext(imm_ext),
      .alu_result(alu_result), .cout(cout), .slt(slt), .overflow(overflow),
      .zero(zero), .result_q(result_q), .flags_q(flags_q)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (instr 0x%08h rs 0x%08h rt 0x%08h)",
                  name, act, exp, instr, rs_data, rt_data);
      end
   endtask

   // Reference: control table per opcode, operation by name, arithmetic in 64 bits.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] rt);
      exp_t        e;
      logic [5:0]  opc;
      logic [3:0]  nib;
      logic [31:0] b;
      int          op;
      longint      sa, sb, sr, ua, ub;
      opc   = ins[31:26];
      e     = '0;
      e.imm = {{16{ins[15]}}, ins[15:0]};
      case (opc)
         6'h00:             e.ctrl = 9'b1_0_0_1_0_0_0_10;
         6'h23:             e.ctrl = 9'b0_1_1_1_1_0_0_00;
         6'h2B:             e.ctrl = 9'b0_1_0_0_0_1_0_00;
         6'h04:             e.ctrl = 9'b0_0_0_0_0_0_1_01;
         6'h08, 6'h0C, 6'h0D: e.ctrl = 9'b0_1_0_1_0_0_0_10;
         default:           e.ctrl = 9'b0;
      endcase
      if (e.ctrl[1:0] == 2'b00)      op = OP_ADD;
      else if (e.ctrl[1:0] == 2'b01) op = OP_SUB;
      else begin
         if (opc == 6'h08)      nib = 4'h0;
         else if (opc == 6'h0C) nib = 4'h4;
         else if (opc == 6'h0D) nib = 4'h5;
         else                   nib = ins[3:0];
         case (nib)
            4'h0: op = OP_ADD;
            4'h2: op = OP_SUB;
            4'h4: op = OP_AND;
            4'h5: op = OP_OR;
            4'hA: op = OP_SLT;
            4'h7: op = OP_NOR;
            default: op = OP_ADD;
         endcase
      end
      case (op)
         OP_ADD: e.alu_ctl = 4'b0010;
         OP_SUB: e.alu_ctl = 4'b0110;
         OP_AND: e.alu_ctl = 4'b0000;
         OP_OR:  e.alu_ctl = 4'b0001;
         OP_SLT: e.alu_ctl = 4'b0111;
         default: e.alu_ctl = 4'b1100;
      endcase
      b     = e.ctrl[7] ? e.imm : rt;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      ua    = longint'(a);
      ub    = longint'(b);
      e.slt = (sa < sb);
      case (op)
         OP_ADD: begin
            e.res  = a + b;
            e.cout = (ua + ub) >= 64'sd4294967296;
            sr     = sa + sb;
            e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         OP_SUB: begin
            e.res  = a - b;
            e.cout = (ua >= ub);
            sr     = sa - sb;
            e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         OP_AND: e.res = a & b;
         OP_OR:  e.res = a | b;
         OP_SLT: e.res = e.slt ? 32'd1 : 32'd0;
         default: e.res = ~(a | b);
      endcase
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 6))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      instr     = ins;
      rs_data   = a;
      rt_data   = b;
      drv_valid = 1'b1;
      sb_q.push_back(model(ins, a, b));
   endtask

   // Monitor: comb outputs and the value registered at this edge belong to the same vector.
   initial begin
      exp_t e;
      logic v;
      forever begin
         @(posedge clk);
         v = drv_valid;
         #1;
         if (v) begin
            if (sb_q.size() == 0) begin
               chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("ctrl", {23'd0, reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
                            mem_write, branch, alu_op}, {23'd0, e.ctrl});
               chk("alu_ctl", {28'd0, alu_ctl}, {28'd0, e.alu_ctl});
               chk("imm_ext", imm_ext, e.imm);
               chk("alu_result", alu_result, e.res);
               chk("flags", {28'd0, cout, slt, overflow, zero},
                   {28'd0, e.cout, e.slt, e.ovf, e.zero});
               chk("result_q", result_q, e.res);
               chk("flags_q", {28'd0, flags_q}, {28'd0, e.cout, e.slt, e.ovf, e.zero});
            end
         end
      end
   end

   initial begin
      logic [31:0] ins;
      logic [5:0]  opcs [8];
      logic [5:0]  functs [7];
      exp_t        e;
      int          guard;
      opcs   = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h3F};
      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00};
      rst     = 1'b1;
      instr   = 32'd0;
      rs_data = 32'd0;
      rt_data = 32'd0;
      #3;
      chk("reset_result_q", result_q, 32'd0);
      chk("reset_flags_q", {28'd0, flags_q}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      issue(32'h8C41_0001, 32'd2, 32'd77);
      issue(32'hACA5_0002, 32'd5, 32'd5);
      issue(32'h2094_FFFF, 32'd4, 32'd0);
      issue(32'h0128_A822, 32'd9, 32'd8);
      issue(32'h0128_A822, 32'd8, 32'd8);
      issue(32'h30D6_0000, 32'd6, 32'd3);
      issue(32'h0128_A82A, 32'hFFFF_FFFF, 32'd1);
      issue(32'h0128_A827, 32'd0, 32'd0);
      issue(32'h0128_A820, 32'h7FFF_FFFF, 32'd1);
      issue(32'hFC00_0000, 32'd3, 32'd4);
      issue(32'h34A5_8001, 32'h0000_1234, 32'd0);
      issue(32'h1085_0003, 32'd5, 32'd5);

      for (int i = 0; i < 300; i++) begin
         ins = $urandom;
         ins[31:26] = ($urandom_range(0, 9) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 7)];
         if (ins[31:26] == 6'h00 && $urandom_range(0, 7) != 0)
            ins[5:0] = functs[$urandom_range(0, 6)];
         issue(ins, pick_val(), pick_val());
      end

      @(negedge clk);
      drv_valid = 1'b0;
      guard = 0;
      while (sb_q.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("scoreboard_drained", sb_q.size(), 32'd0);

      // Asynchronous reset in the middle of a cycle, with no edge in between.
      e       = model(32'h0128_A820, 32'd5, 32'd6);
      instr   = 32'h0128_A820;
      rs_data = 32'd5;
      rt_data = 32'd6;
      @(posedge clk);
      #1;
      chk("pre_rst_result_q", result_q, e.res);
      chk("pre_rst_flags_q", {28'd0, flags_q}, {28'd0, e.cout, e.slt, e.ovf, e.zero});
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_result_q", result_q, 32'd0);
      chk("async_rst_flags_q", {28'd0, flags_q}, 32'd0);
      chk("rst_comb_result", alu_result, e.res);
      @(posedge clk);
      #1;
      chk("rst_hold_result_q", result_q, 32'd0);
      chk("rst_hold_flags_q", {28'd0, flags_q}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_result_q", result_q, e.res);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
